// File: rtl/aes256_inv_key_schedule_pkg.sv
// Shared constants, FSM state type and round-key packing for the inverse AES-256 key schedule.
package aes256_inv_key_schedule_pkg;

  localparam int unsigned NK = 8;   // key words in the sliding window
  localparam int unsigned NR = 14;  // last round number

  typedef enum logic [2:0] {
    StIdle,
    StEmitHi,
    StEmitLo,
    StGen,
    StFin
  } state_e;

  // Round constant for word index i, looked up by i/8 (valid for 1..7).
  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] val;
    case (idx)
      3'd1:    val = 8'h01;
      3'd2:    val = 8'h02;
      3'd3:    val = 8'h04;
      3'd4:    val = 8'h08;
      3'd5:    val = 8'h10;
      3'd6:    val = 8'h20;
      3'd7:    val = 8'h40;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  // Round key word order: w[4r] occupies the top 32 bits, w[4r+3] the bottom.
  function automatic logic [127:0] pack_rk(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes256_inv_key_schedule_sbox.sv
// Combinational forward AES S-box, one byte.
module aes256_inv_key_schedule_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[x];

endmodule

// File: rtl/aes256_inv_key_schedule.sv
// Reverse AES-256 key schedule: from {rk13, rk14} regenerate rk14..rk0, one word per cycle.
module aes256_inv_key_schedule
  import aes256_inv_key_schedule_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [255:0] last_key,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  // win_q[k] holds w[i-7+k]: win_q[NK-1] is w[i], win_q[0] is w[i-7].
  logic [31:0]  win_q [NK];
  logic [31:0]  win_d [NK];
  logic [5:0]   idx_q, idx_d;
  logic [3:0]   r_q, r_d;

  logic         rk_valid_d, busy_d, done_d;
  logic [127:0] rk_data_d;
  logic [3:0]   rk_index_d;

  logic [31:0]  prev_word, sub_in, sub_out, f_out, new_word;

  assign prev_word = win_q[NK-2];
  // RotWord only on the rcon positions (i%8==0).
  assign sub_in    = (idx_q[2:0] == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes256_inv_key_schedule_sbox u_sbox (
      .x(sub_in[8*b +: 8]),
      .y(sub_out[8*b +: 8])
    );
  end

  // f(w[i-1]) selected by i mod 8.
  always_comb begin
    f_out = prev_word;
    if (idx_q[2:0] == 3'd0) begin
      f_out = sub_out ^ {rcon(idx_q[5:3]), 24'h0};
    end else if (idx_q[2:0] == 3'd4) begin
      f_out = sub_out;
    end
  end

  assign new_word = win_q[NK-1] ^ f_out;

  // Next state, window shift and round counter.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    r_d     = r_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StEmitHi;
            for (int k = 0; k < NK; k++) begin
              win_d[k] = last_key[255-32*k -: 32];
            end
            idx_d = 6'd59;
            r_d   = 4'(NR - 1);
          end
        end
        StEmitHi: begin
          if (rk_ready) state_d = StEmitLo;
        end
        StEmitLo: begin
          if (rk_ready) state_d = (r_q == 4'd0) ? StFin : StGen;
        end
        StGen: begin
          for (int k = 1; k < NK; k++) begin
            win_d[k] = win_q[k-1];
          end
          win_d[0] = new_word;
          idx_d    = idx_q - 6'd1;
          // Four words per round key: the step at i%4==0 completes it.
          if (idx_q[1:0] == 2'd0) begin
            state_d = StEmitLo;
            r_d     = r_q - 4'd1;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state so they register cleanly.
  always_comb begin
    rk_valid_d = 1'b0;
    rk_data_d  = '0;
    rk_index_d = '0;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StFin);
    if (state_d == StEmitHi) begin
      rk_valid_d = 1'b1;
      rk_data_d  = pack_rk(win_d[4], win_d[5], win_d[6], win_d[7]);
      rk_index_d = 4'(NR);
    end else if (state_d == StEmitLo) begin
      rk_valid_d = 1'b1;
      rk_data_d  = pack_rk(win_d[0], win_d[1], win_d[2], win_d[3]);
      rk_index_d = r_d;
    end
  end

  // State, window and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      for (int k = 0; k < NK; k++) begin
        win_q[k] <= '0;
      end
      idx_q    <= '0;
      r_q      <= '0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      idx_q    <= idx_d;
      r_q      <= r_d;
      rk_valid <= rk_valid_d;
      rk_data  <= rk_data_d;
      rk_index <= rk_index_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_aes256_inv_key_schedule.sv
// Bench for the reverse AES-256 key schedule against a forward key-expansion model.
module tb_aes256_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [255:0] last_key;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  ref_w  [60];
  logic [127:0] got_rk [15];

  localparam logic [7:0] SB [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  aes256_inv_key_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .last_key (last_key),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_data  (rk_data),
    .rk_index (rk_index),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
  endfunction

  // Forward AES-256 key expansion into ref_w.
  task automatic fill_ref(input logic [255:0] key);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) ref_w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = ref_w[i-1];
      if (i % 8 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      ref_w[i] = ref_w[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_rk(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  // Load {rk13, rk14} from the model and pulse start; returns at the negedge of cycle 1.
  task automatic kick();
    @(negedge clk);
    last_key = {ref_rk(13), ref_rk(14)};
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Full run: every valid cycle must show the next expected key, stalls included.
  task automatic run_keys(input logic [255:0] key, input bit rnd, input bit disturb);
    int exp_idx, cyc, stall, hs;
    bit got_done;
    fill_ref(key);
    rk_ready = rnd ? 1'b0 : 1'b1;
    kick();
    cyc = 1; exp_idx = 14; stall = 0; hs = 0; got_done = 0;
    chk("rk14_latency", 128'(rk_valid), 128'(1));
    while (!got_done && cyc < 3000) begin
      if (rnd) begin
        if (stall > 0) begin
          rk_ready = 1'b0;
          stall--;
        end else if ($urandom_range(0, 15) == 0) begin
          rk_ready = 1'b0;
          stall    = 20;
        end else begin
          rk_ready = 1'($urandom_range(0, 1));
        end
      end
      if (disturb) begin
        start    = ($urandom_range(0, 3) == 0);
        last_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (rk_valid) begin
        if (exp_idx < 0) begin
          chk("extra_key", 128'(rk_index), 128'hffff);
        end else begin
          chk("rk_index", 128'(rk_index), 128'(exp_idx));
          chk("rk_data", rk_data, ref_rk(exp_idx));
          if (rk_ready) begin
            got_rk[exp_idx] = rk_data;
            exp_idx--;
            hs++;
          end
        end
      end
      if (done) begin
        got_done = 1'b1;
        if (!rnd) chk("done_cycle", 128'(cyc), 128'(68));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("got_done", 128'(got_done), 128'(1));
    chk("handshakes", 128'(hs), 128'(15));
    chk("idle_after_done", 128'(busy), 128'(0));
    chk("done_one_cycle", 128'(done), 128'(0));
  endtask

  initial begin
    int cyc;
    bit seen_done;
    logic [255:0] k1;
    logic [255:0] k2;

    rst = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b0; last_key = '0;
    #3;
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_data", rk_data, 128'(0));
    chk("rst_index", 128'(rk_index), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 128'(busy), 128'(0));

    // FIPS-197 A.3 key, ready held high.
    run_keys(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0, 1'b0);
    chk("fips_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("fips_rk1", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("fips_rk0", got_rk[0], 128'h603deb1015ca71be2b73aef0857d7781);

    k1 = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    k2 = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    run_keys(k1, 1'b0, 1'b0);
    run_keys(k1, 1'b1, 1'b0);
    run_keys(k2, 1'b1, 1'b1);

    // Abort in the second GEN cycle of rk7 (cycle 29), with a start in the same cycle.
    fill_ref(k2);
    rk_ready = 1'b1;
    kick();
    cyc = 1;
    while (cyc < 29) begin
      @(negedge clk);
      cyc++;
    end
    chk("gen_busy", 128'(busy), 128'(1));
    chk("gen_no_valid", 128'(rk_valid), 128'(0));
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_valid", 128'(rk_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    seen_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (done || busy) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_quiet", 128'(seen_done), 128'(0));
    run_keys(k2, 1'b0, 1'b0);

    // Asynchronous reset mid-GEN.
    fill_ref(k1);
    kick();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 128'(busy), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_valid", 128'(rk_valid), 128'(0));
    chk("arst_data", rk_data, 128'(0));
    chk("arst_index", 128'(rk_index), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 128'(busy), 128'(0));
    run_keys(k1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
